// File: rtl/apb_master_pkg.sv
// apb_master_pkg: FSM state and response code types shared by the APB master bridge
package apb_master_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_SLVERR   = 2'd1,
    RSP_TIMEOUT  = 2'd2,
    RSP_MISALIGN = 2'd3
  } rsp_code_e;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: clearable wait-cycle counter; clk/rst, clr_i, en_i in, expired_o high at count LIMIT-1
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired_o = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command/response to single-outstanding APB4 initiator with misalign check and ACCESS timeout
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [31:0]       cmd_wdata_i,
  input  logic [3:0]        cmd_strb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic [1:0]        rsp_code_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [31:0]       pwdata_o,
  output logic [3:0]        pstrb_o,
  input  logic              pready_i,
  input  logic [31:0]       prdata_i,
  input  logic              pslverr_i
);
  state_e            state_q, state_d;
  rsp_code_e         code_q, code_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        strb_q, strb_d;
  logic              expired, accept;
  apb_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk      (pclk_i),
    .rst      (preset_i),
    .clr_i    (state_q != ACCESS),
    .en_i     (!pready_i),
    .expired_o(expired)
  );
  assign cmd_ready_o = (state_q == IDLE) && !preset_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = state_q == ACCESS;
  assign paddr_o     = addr_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = strb_q;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_code_o  = code_q;
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        rdata_d = '0;
        if (cmd_addr_i[1:0] == 2'b00) begin
          addr_d  = cmd_addr_i;
          write_d = cmd_write_i;
          wdata_d = cmd_write_i ? cmd_wdata_i : '0;
          strb_d  = cmd_write_i ? cmd_strb_i : '0;
          state_d = SETUP;
        end else begin
          code_d  = RSP_MISALIGN;
          state_d = RESP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (pready_i) begin
        rdata_d = (!write_q && !pslverr_i) ? prdata_i : '0;
        code_d  = pslverr_i ? RSP_SLVERR : RSP_OK;
        state_d = RESP;
      end else if (expired) begin
        rdata_d = '0;
        code_d  = RSP_TIMEOUT;
        state_d = RESP;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q <= IDLE;
      code_q  <= RSP_OK;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;
  localparam int TO = 16;
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  code;
  } rsp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_code;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  int          slv_wait = 0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt = 0;
  int          total = 0, bad = 0;
  rsp_t        sb[$];
  always #5 clk = ~clk;
  apb_master_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk_i(clk), .preset_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_code_o(rsp_code),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );
  always @(posedge clk) acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;
  assign pready  = psel && penable && (acc_cnt == slv_wait);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input int wt, input logic err,
                     input logic [31:0] rd, input int hold);
    rsp_t e;
    logic misal, ok;
    int   sel_n, setup_n, acc_n, lat, exp_acc;
    misal = addr[1:0] != 2'b00;
    slv_wait = wt;
    slv_err = err;
    slv_rdata = rd;
    e.code = misal ? 2'd3 : (wt >= TO) ? 2'd2 : err ? 2'd1 : 2'd0;
    e.rdata = (e.code == 2'd0 && !wr) ? rd : 32'h0;
    sb.push_back(e);
    exp_acc = misal ? 0 : (wt >= TO) ? TO : wt + 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = addr;
    cmd_wdata = wdata;
    cmd_strb = strb;
    rsp_ready = (hold == 0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    chk("accept", ok, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr = $urandom;
    cmd_wdata = $urandom;
    cmd_strb = 4'h5;
    sel_n = 0;
    setup_n = 0;
    acc_n = 0;
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (psel) sel_n++;
      if (psel && !penable) setup_n++;
      if (penable) begin
        acc_n++;
        chk("psel_in_access", psel, 1);
        chk("paddr", paddr, addr);
        chk("pwrite", pwrite, wr);
        chk("pstrb", pstrb, wr ? strb : 4'h0);
        chk("pwdata", pwdata, wr ? wdata : 32'h0);
      end
      if (rsp_valid) lat = n;
    end
    chk("latency", lat, misal ? 1 : exp_acc + 2);
    chk("setup_cycles", setup_n, misal ? 0 : 1);
    chk("access_cycles", acc_n, exp_acc);
    chk("sel_cycles", sel_n, misal ? 0 : exp_acc + 1);
    e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_code", rsp_code, e.code);
    chk("rsp_psel", psel, 0);
    chk("rsp_penable", penable, 0);
    chk("rsp_cmd_ready", cmd_ready, 0);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_rdata", rsp_rdata, e.rdata);
        chk("hold_code", rsp_code, e.code);
        chk("hold_cmd_ready", cmd_ready, 0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_paddr", paddr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    run(1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 0, 1'b0, 32'hA5A5_A5A5, 0);
    run(1'b0, 32'h0000_0004, 32'h0, 4'h0, 3, 1'b0, 32'hDEAD_BEEF, 0);
    run(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 1'b1, 32'h55AA_55AA, 0);
    run(1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h0, 0);
    run(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1000, 1'b0, 32'h1111_1111, 0);
    run(1'b0, 32'h0000_0024, 32'h0, 4'h0, TO - 1, 1'b0, 32'h8765_4321, 0);
    run(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'h3, 2, 1'b1, 32'h2222_2222, 0);
    slv_wait = 1000;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h0000_0010;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_penable", penable, 1);
    @(negedge clk);
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    chk("midrst_no_rsp", rsp_valid, 0);
    run(1'b0, 32'h0000_000C, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D, 10);
    run(1'b1, 32'h0000_0041, 32'h0, 4'hF, 0, 1'b0, 32'h0, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Single-outstanding APB initiator that turns a simple valid/ready command/response interface into APB4 SETUP/ACCESS transfers. Sits between a local requester (DMA helper, debug bridge, test sequencer) and the peripheral APB segment that hosts slaves such as the 7-segment display wrapper. Adds alignment checking and a bounded-wait timeout so a missing or stalled slave cannot hang the requester.

Parameters:
ADDR_W, 32, width of command and APB address
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles waiting for pready_i before abort (>=2)

Ports:
pclk_i  in  1  clock; all logic on rising edge
preset_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o
cmd_write_i  in  1  1 = write, 0 = read
cmd_addr_i  in  ADDR_W  byte address
cmd_wdata_i  in  32  write data
cmd_strb_i  in  4  write byte strobes
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i
rsp_rdata_o  out  32  read data (0 for writes and errors)
rsp_code_o  out  2  0 OK, 1 SLVERR, 2 TIMEOUT, 3 MISALIGN
paddr_o  out  ADDR_W  APB address
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  32  APB write data
pstrb_o  out  4  APB strobes
pready_i  in  1  slave ready
prdata_i  in  32  slave read data
pslverr_i  in  1  slave error

Behaviour:
- One clock, pclk_i; reset synchronous active-high (preset_i). In reset: state IDLE, all outputs 0 (cmd_ready_o asserts the first cycle after reset release).
- FSM states IDLE, SETUP, ACCESS, RESP. cmd_ready_o = (state == IDLE).
- IDLE: on accept with cmd_addr_i[1:0] == 0, register addr/write/wdata/strb and go to SETUP. With cmd_addr_i[1:0] != 0, go directly to RESP with code MISALIGN and rdata 0; no APB activity.
- SETUP (exactly 1 cycle): psel_o=1, penable_o=0, paddr/pwrite/pwdata/pstrb driven from registers. Reads drive pstrb_o=0 and pwdata_o=0. Then go to ACCESS.
- ACCESS: psel_o=1, penable_o=1, all APB outputs held stable. Wait-cycle counter starts at 0 and increments each ACCESS cycle without pready_i.
  - pready_i=1: capture prdata_i (reads only, else 0); code = pslverr_i ? SLVERR : OK; SLVERR reads return rdata 0; go to RESP.
  - pready_i=0 and counter == TIMEOUT_CYCLES-1: abort, code TIMEOUT, rdata 0, go to RESP.
  - pready_i and the timeout condition in the same cycle: pready_i wins.
- RESP: psel_o=0, penable_o=0; rsp_valid_o=1 with stable rdata/code until rsp_ready_i; then IDLE. Because responses are registered, rsp_ready_i high on entry still gives one RESP cycle.
- psel_o and penable_o are 0 in IDLE and RESP. There are no back-to-back transfers without IDLE; the next SETUP comes at the earliest 1 cycle after RESP.
- Latency, zero-wait slave with rsp_ready_i held high: accept at cycle 0, SETUP c1, ACCESS c2, rsp_valid_o c3, cmd_ready_o c4.
- Reset mid-transfer in any state: next edge forces IDLE and zero outputs. The pending response is discarded.
- pslverr_i and prdata_i are ignored outside ACCESS with pready_i.

Decomposition:
- Package apb_master_pkg holds the state enum (IDLE, SETUP, ACCESS, RESP) and the rsp_code enum (RSP_OK=0, RSP_SLVERR=1, RSP_TIMEOUT=2, RSP_MISALIGN=3).
- One sub-module, apb_wait_timer: a counter with clear/enable that asserts expired at TIMEOUT_CYCLES-1. All other logic stays in a single module.

Test Plan:
- Write addr 0x0000, wdata 0x12345678, strb 0xF, slave pready on first ACCESS -> psel 1 at c1 and c2, penable 1 only at c2, pwrite 1, pstrb 0xF. rsp_valid at c3 with code 0 and rdata 0.
- Read addr 0x0004, slave inserts 3 wait states then returns 0xDEADBEEF -> penable held 4 cycles with paddr stable and pstrb 0. rsp_rdata 0xDEADBEEF, code 0.
- Read addr 0x0008, slave pready with pslverr=1 -> code 1, rdata 0. psel/penable drop the cycle after pready.
- Command addr 0x0002 -> no psel assertion at any cycle; rsp_valid the cycle after accept with code 3.
- pready never asserted, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then psel 0 and code 2. Repeat with pready rising on ACCESS cycle 16 -> code 0.
- preset_i pulsed during ACCESS -> next cycle psel/penable/rsp_valid 0 and cmd_ready 1 after release. With rsp_ready_i held low, rsp_valid stays high and stable for 10 cycles and cmd_ready stays 0.
